// File: rtl/gpr_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register pending-write scoreboard. Register 0 reads as zero and is never busy.
module gpr_mp #(
  parameter int XLEN     = 32,
  parameter int NR_REG   = 32,
  parameter int NR_RPORT = 2,
  parameter int NR_WPORT = 1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NR_WPORT-1:0]      wen,
  input  logic [5*NR_WPORT-1:0]    waddr,
  input  logic [XLEN*NR_WPORT-1:0] wdata,
  input  logic [5*NR_RPORT-1:0]    raddr,
  output logic [XLEN*NR_RPORT-1:0] rdata,
  output logic [NR_RPORT-1:0]      rbusy,
  input  logic                     sb_set,
  input  logic [4:0]               sb_addr,
  input  logic                     sb_flush
);

  localparam int AW = 5;
  localparam int IW = (NR_REG > 2) ? $clog2(NR_REG) : 1;

  logic [XLEN-1:0] regs [NR_REG];
  logic [NR_REG-1:0] busy;

  // Per-register view of this cycle's writes and scoreboard set.
  logic [NR_REG-1:0] wr_hit;
  logic [XLEN-1:0]   wr_val [NR_REG];
  logic [NR_REG-1:0] set_hit;

  always_comb begin : write_decode
    wr_hit  = '0;
    set_hit = '0;
    for (int k = 0; k < NR_REG; k++) wr_val[k] = '0;
    // NOTE: blocking assignments in an ascending loop let a higher-index port
    // overwrite a lower one, which is exactly the write-port priority.
    for (int k = 1; k < NR_REG; k++) begin
      for (int i = 0; i < NR_WPORT; i++) begin
        if (wen[i] && waddr[AW*i +: AW] == AW'(k)) begin
          wr_hit[k] = 1'b1;
          wr_val[k] = wdata[XLEN*i +: XLEN];
        end
      end
      set_hit[k] = sb_set && (sb_addr == AW'(k));
    end
  end

  // NOTE: the register array is deliberately reset, since a reset must zero
  // every architectural register immediately rather than leave stale data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NR_REG; k++) regs[k] <= '0;
    end else begin
      for (int k = 1; k < NR_REG; k++) begin
        if (wr_hit[k]) regs[k] <= wr_val[k];
      end
    end
  end

  // A new producer issued in the same cycle as an older one retires keeps the
  // register pending, so set wins over clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else if (sb_flush) begin
      busy <= '0;
    end else begin
      for (int k = 1; k < NR_REG; k++) begin
        if (set_hit[k])     busy[k] <= 1'b1;
        else if (wr_hit[k]) busy[k] <= 1'b0;
      end
    end
  end

  always_comb begin : read_ports
    logic [AW-1:0] ra;
    logic [IW-1:0] ri;
    rdata = '0;
    rbusy = '0;
    for (int j = 0; j < NR_RPORT; j++) begin
      ra = raddr[AW*j +: AW];
      ri = ra[IW-1:0];
      if (!reset && ra != '0 && int'(ra) < NR_REG) begin
        if (BYPASS && wr_hit[ri]) rdata[XLEN*j +: XLEN] = wr_val[ri];
        else                      rdata[XLEN*j +: XLEN] = regs[ri];
        // With forwarding the consumer already gets the data, so no stall.
        rbusy[j] = busy[ri] & ~(BYPASS && wr_hit[ri]);
      end
    end
  end

endmodule

// File: tb/tb_gpr_mp.sv
// Directed bench for gpr_mp: a bypassing 2-write-port/32-register instance and
// a non-bypassing 1-write-port/16-register instance, sharing clock and reset.
module tb_gpr_mp;

  logic clock;
  logic reset;

  // Instance A: BYPASS=1, NR_WPORT=2, NR_REG=32
  logic [1:0]  a_wen;
  logic [9:0]  a_waddr;
  logic [63:0] a_wdata;
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [1:0]  a_rbusy;
  logic        a_sb_set;
  logic [4:0]  a_sb_addr;
  logic        a_sb_flush;

  // Instance B: BYPASS=0, NR_WPORT=1, NR_REG=16
  logic [0:0]  b_wen;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic [9:0]  b_raddr;
  logic [63:0] b_rdata;
  logic [1:0]  b_rbusy;
  logic        b_sb_set;
  logic [4:0]  b_sb_addr;
  logic        b_sb_flush;

  int n_tests = 0;
  int n_fail  = 0;

  gpr_mp #(.XLEN(32), .NR_REG(32), .NR_RPORT(2), .NR_WPORT(2), .BYPASS(1'b1)) u_dut_a (
    .clock(clock), .reset(reset),
    .wen(a_wen), .waddr(a_waddr), .wdata(a_wdata),
    .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
    .sb_set(a_sb_set), .sb_addr(a_sb_addr), .sb_flush(a_sb_flush)
  );

  gpr_mp #(.XLEN(32), .NR_REG(16), .NR_RPORT(2), .NR_WPORT(1), .BYPASS(1'b0)) u_dut_b (
    .clock(clock), .reset(reset),
    .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata),
    .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
    .sb_set(b_sb_set), .sb_addr(b_sb_addr), .sb_flush(b_sb_flush)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic a_idle();
    a_wen = '0; a_sb_set = 1'b0; a_sb_flush = 1'b0;
  endtask

  task automatic b_idle();
    b_wen = '0; b_sb_set = 1'b0; b_sb_flush = 1'b0;
  endtask

  task automatic a_wr(input int p, input logic [4:0] addr, input logic [31:0] d);
    a_wen[p] = 1'b1;
    a_waddr[5*p +: 5]  = addr;
    a_wdata[32*p +: 32] = d;
  endtask

  task automatic b_wr(input logic [4:0] addr, input logic [31:0] d);
    b_wen = 1'b1; b_waddr = addr; b_wdata = d;
  endtask

  task automatic a_sb(input logic [4:0] addr);
    a_sb_set = 1'b1; a_sb_addr = addr;
  endtask

  function automatic logic [31:0] a_rd(input int p);
    return a_rdata[32*p +: 32];
  endfunction

  function automatic logic [31:0] b_rd(input int p);
    return b_rdata[32*p +: 32];
  endfunction

  initial begin
    reset = 1'b1;
    a_waddr = '0; a_wdata = '0; a_raddr = '0; a_sb_addr = '0; a_idle();
    b_waddr = '0; b_wdata = '0; b_raddr = '0; b_sb_addr = '0; b_idle();

    // While reset is held even a bypassable write must not reach rdata.
    a_wr(0, 5'd3, 32'h0BAD0BAD);
    a_raddr = {5'd0, 5'd3};
    #1;
    check("rst_rdata", a_rd(0), 32'h0);
    check("rst_rbusy", {30'b0, a_rbusy}, 32'h0);
    a_idle();
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;

    // Plain write, read next cycle on port 1
    a_wr(0, 5'd3, 32'h12345678);
    a_raddr = {5'd3, 5'd0};
    tick(); a_idle(); #1;
    check("wr_rd_x3", a_rd(1), 32'h12345678);

    // x0 is hard-wired zero, not forwarded either
    a_wr(0, 5'd0, 32'hFFFFFFFF);
    a_raddr = {5'd0, 5'd0};
    #1;
    check("x0_bypass", a_rd(0), 32'h0);
    tick(); a_idle(); #1;
    check("x0_read", a_rd(0), 32'h0);

    // Same-cycle forwarding
    a_wr(0, 5'd7, 32'hA5A5A5A5);
    a_raddr = {5'd3, 5'd7};
    #1;
    check("bypass_same_cycle", a_rd(0), 32'hA5A5A5A5);
    tick(); a_idle(); #1;
    check("bypass_stored", a_rd(0), 32'hA5A5A5A5);

    // Both write ports hit x9: port 1 wins, forwarded and stored
    a_wr(0, 5'd9, 32'h1);
    a_wr(1, 5'd9, 32'h2);
    a_raddr = {5'd3, 5'd9};
    #1;
    check("conflict_bypass", a_rd(0), 32'h2);
    tick(); a_idle(); #1;
    check("conflict_stored", a_rd(0), 32'h2);

    // Scoreboard set is visible only after the edge
    a_sb(5'd4);
    a_raddr = {5'd3, 5'd4};
    #1;
    check("sb_set_not_comb", {31'b0, a_rbusy[0]}, 32'h0);
    tick(); a_idle(); #1;
    check("sb_busy_next", {31'b0, a_rbusy[0]}, 32'h1);
    check("sb_other_port", {31'b0, a_rbusy[1]}, 32'h0);
    a_wr(0, 5'd4, 32'h44);
    #1;
    check("sb_clear_bypass", {31'b0, a_rbusy[0]}, 32'h0);
    check("x4_bypass", a_rd(0), 32'h44);
    tick(); a_idle(); #1;
    check("sb_cleared", {31'b0, a_rbusy[0]}, 32'h0);

    // Set and write of the same register: stays busy, data still stored
    a_sb(5'd4);
    a_wr(0, 5'd4, 32'h55);
    tick(); a_idle(); #1;
    check("set_beats_clear", {31'b0, a_rbusy[0]}, 32'h1);
    check("x4_stored", a_rd(0), 32'h55);

    // Flush wins over a simultaneous set and leaves contents alone
    a_sb(5'd1); tick();
    a_sb(5'd2); tick();
    a_sb(5'd31); tick();
    a_idle();
    a_raddr = {5'd1, 5'd31};
    #1;
    check("busy_x31_x1", {30'b0, a_rbusy}, 32'h3);
    a_sb_flush = 1'b1;
    a_sb(5'd6);
    tick(); a_idle(); #1;
    check("flush_x31_x1", {30'b0, a_rbusy}, 32'h0);
    a_raddr = {5'd6, 5'd2};
    #1;
    check("flush_x2_x6", {30'b0, a_rbusy}, 32'h0);
    a_raddr = {5'd3, 5'd4};
    #1;
    check("flush_x4", {30'b0, a_rbusy}, 32'h0);
    check("flush_keeps_x4", a_rd(0), 32'h55);
    check("flush_keeps_x3", a_rd(1), 32'h12345678);

    // Non-bypassing instance: old value in the write cycle, new one after
    b_wr(5'd7, 32'h11111111);
    tick(); b_idle();
    b_wr(5'd7, 32'hA5A5A5A5);
    b_raddr = {5'd0, 5'd7};
    #1;
    check("nobypass_old", b_rd(0), 32'h11111111);
    tick(); b_idle(); #1;
    check("nobypass_new", b_rd(0), 32'hA5A5A5A5);

    // NR_REG=16: address 20 is neither written nor aliased onto x4
    b_wr(5'd20, 32'hCAFEF00D);
    b_raddr = {5'd4, 5'd20};
    tick(); b_idle(); #1;
    check("oob_read", b_rd(0), 32'h0);
    check("oob_no_alias", b_rd(1), 32'h0);

    // Without bypass a retiring write does not hide busy in its own cycle
    b_sb_set = 1'b1; b_sb_addr = 5'd4;
    tick(); b_idle(); #1;
    check("b_busy_x4", {31'b0, b_rbusy[1]}, 32'h1);
    b_wr(5'd4, 32'h77);
    #1;
    check("b_busy_during_wr", {31'b0, b_rbusy[1]}, 32'h1);
    tick(); b_idle(); #1;
    check("b_busy_cleared", {31'b0, b_rbusy[1]}, 32'h0);
    check("b_x4_stored", b_rd(1), 32'h77);

    // Out-of-range sb_addr must not alias onto x4
    b_sb_set = 1'b1; b_sb_addr = 5'd20;
    tick(); b_idle(); #1;
    check("b_sb_oob", {31'b0, b_rbusy[1]}, 32'h0);

    // Mid-run reset clears contents and busy without waiting for an edge
    a_wr(0, 5'd5, 32'hDEADBEEF);
    a_sb(5'd5);
    a_raddr = {5'd3, 5'd5};
    tick(); a_idle(); #1;
    check("x5_before_rst", a_rd(0), 32'hDEADBEEF);
    check("x5_busy_before_rst", {31'b0, a_rbusy[0]}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_x5", a_rd(0), 32'h0);
    check("async_rst_busy", {30'b0, a_rbusy}, 32'h0);
    @(posedge clock);
    #2 reset = 1'b0;
    tick();
    check("post_rst_x5", a_rd(0), 32'h0);
    check("post_rst_x3", a_rd(1), 32'h0);
    check("post_rst_busy", {30'b0, a_rbusy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_mp.md
Name: gpr_mp

Overview:
- Parametrised integer register file, successor to the single-write/dual-read GPR.
- Adds configurable read/write port counts, optional write-to-read bypass and a per-register pending-write scoreboard (busy bits) with flush.
- Sits between decode/issue (reads, busy query, busy set) and writeback (writes, busy clear).
- Register 0 is hard-wired zero and never busy.

Parameters:
- XLEN, 32, data width in bits.
- NR_REG, 32, number of architectural registers (16 for RV32E); address width AW = 5 fixed.
- NR_RPORT, 2, number of read ports.
- NR_WPORT, 1, number of write ports; higher index has priority.
- BYPASS, 1, 1 = same-cycle write data is forwarded to read ports; 0 = reads see registered state only.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all registers and busy bits.
- wen  in  NR_WPORT  per-port write enable.
- waddr  in  5*NR_WPORT  per-port write address, port i at [5i+4:5i].
- wdata  in  XLEN*NR_WPORT  per-port write data.
- raddr  in  5*NR_RPORT  per-port read address.
- rdata  out  XLEN*NR_RPORT  per-port read data.
- rbusy  out  NR_RPORT  per-port "register has a pending write" flag.
- sb_set  in  1  mark sb_addr busy (issue of an instruction writing sb_addr).
- sb_addr  in  5  register to mark busy.
- sb_flush  in  1  synchronously clear all busy bits.

Behaviour:
- Reset (async, active-high): every register = 0 and every busy bit = 0 immediately. While reset is held, rdata = 0 and rbusy = 0 for all ports. The first update happens on the first posedge after reset deasserts.
- Write:
  - On posedge, for each port i with wen[i]=1, 0<waddr_i<NR_REG: r[waddr_i] <= wdata_i.
  - Address 0 or address >= NR_REG: write ignored.
  - Two ports writing the same address in the same cycle: highest-index port wins.
- Read (combinational, zero latency):
  - raddr=0 or raddr>=NR_REG: rdata=0, rbusy=0.
  - BYPASS=1 and some enabled write port targets raddr (nonzero, in range) this cycle: rdata = that port's wdata, using the same priority as the write.
  - Otherwise rdata = r[raddr].
- Scoreboard, per register k in 1..NR_REG-1:
  - Clear condition: any enabled write port targets k.
  - Set condition: sb_set=1 and sb_addr=k.
  - Next-state priority: sb_flush (all 0) > set (1) > clear (0) > hold.
  - Set beats clear on the same register: the newer producer is still pending.
  - sb_set with sb_addr=0 or sb_addr>=NR_REG: ignored.
- rbusy:
  - BYPASS=1: rbusy = busy[raddr] & ~(same-cycle clear of raddr). Data is forwarded, so the consumer need not stall.
  - BYPASS=0: rbusy = busy[raddr].
  - sb_set in the current cycle never affects rbusy (registered effect only).
- Writes while busy=0 are legal: data is stored and busy stays 0.
- sb_flush does not alter register contents.
- No internal state besides r[] and busy[]; no handshakes; all outputs are combinational from state and current inputs.

Test Plan:
- Reset then read: assert reset mid-simulation after writing r5=0xDEADBEEF -> rdata for raddr=5 reads 0 asynchronously, before any clock edge; rbusy=0.
- Write/read with zero handling:
  - wen0=1, waddr=3, wdata=0x12345678, then read port1 raddr=3 next cycle -> 0x12345678.
  - Write to x0 -> read x0 = 0.
  - NR_REG=16: write addr 20 ignored, read addr 20 = 0.
- Bypass:
  - BYPASS=1: write x7=0xA5A5A5A5 while port0 raddr=7 in the same cycle -> rdata=0xA5A5A5A5 in that cycle.
  - BYPASS=0: same stimulus -> old value in that cycle, new value next cycle.
- Write-port conflict: NR_WPORT=2, both ports write x9 (port0=0x1, port1=0x2) -> x9=0x2; bypassed rdata also 0x2.
- Scoreboard:
  - sb_set x4 -> rbusy for x4 = 1 from the next cycle.
  - Write x4 -> busy 0 after the edge; with BYPASS=1, rbusy=0 already during the write cycle.
  - sb_set x4 and write x4 in the same cycle -> busy stays 1.
- Flush: set busy on x1, x2, x31, then sb_flush=1 together with sb_set x6 -> all busy bits 0 including x6; register contents unchanged.
